// File: rtl/usb_pkg.sv
// Shared types and constants for the USB transmit bit-stuffing path.
package usb_pkg;

    typedef enum logic {
        PASS  = 1'b0,
        STUFF = 1'b1
    } stuff_state_t;

    localparam int USB_STUFF_RUN_LEN = 6;

    // One line beat as it will appear on the output registers next cycle.
    typedef struct packed {
        logic valid;
        logic data;
        logic last;
    } line_beat_t;

endpackage

// File: rtl/usb_bit_stuffer_nrzi.sv
// NRZI line encoder: a 0 toggles the line level, a 1 holds it.
// Level idles at 1 (J) and snaps back to 1 the cycle after a packet's last beat.
module nrzi_encoder (
    input  logic clock,
    input  logic reset_n,
    input  logic valid,
    input  logic last,
    input  logic raw_bit,
    output logic level
);

    logic last_q;
    logic base;

    // The level that precedes this beat: idle J once the previous packet ended.
    assign base = last_q ? 1'b1 : level;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            level  <= 1'b1;
            last_q <= 1'b0;
        end else begin
            level  <= (valid && !raw_bit) ? ~base : base;
            last_q <= valid && last;
        end
    end

endmodule

// File: rtl/usb_bit_stuffer.sv
// USB transmit bit stuffer: inserts a 0 after RUN_LEN consecutive 1s, stalling upstream one cycle.
// Define USB_BIT_STUFF_NRZI_EN to NRZI-encode out_bit; otherwise out_bit is the raw stuffed stream.
module usb_bit_stuffer
    import usb_pkg::*;
#(
    parameter int RUN_LEN = USB_STUFF_RUN_LEN
) (
    input  logic clock,
    input  logic reset_n,
    input  logic in_valid,
    input  logic in_bit,
    input  logic in_last,
    output logic in_ready,
    output logic out_valid,
    output logic out_bit,
    output logic out_last
);

    stuff_state_t state, state_nxt;
    logic [2:0]   ones_cnt, cnt_nxt;
    logic         pend_last, pend_nxt;
    logic         accept;
    line_beat_t   beat_nxt;

    assign in_ready = (state == PASS);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = ones_cnt;
        pend_nxt  = pend_last;
        beat_nxt  = '{valid: 1'b0, data: 1'b1, last: 1'b0};
        case (state)
            PASS: begin
                if (accept) begin
                    beat_nxt.valid = 1'b1;
                    beat_nxt.data  = in_bit;
                    if (in_bit && ones_cnt == 3'(RUN_LEN - 1)) begin
                        // Run complete: the packet's end marker moves to the stuffed 0.
                        state_nxt = STUFF;
                        pend_nxt  = in_last;
                        cnt_nxt   = ones_cnt + 3'd1;
                    end else begin
                        beat_nxt.last = in_last;
                        cnt_nxt       = (in_bit && !in_last) ? ones_cnt + 3'd1 : 3'd0;
                    end
                end
            end
            STUFF: begin
                beat_nxt  = '{valid: 1'b1, data: 1'b0, last: pend_last};
                cnt_nxt   = 3'd0;
                pend_nxt  = 1'b0;
                state_nxt = PASS;
            end
            default: state_nxt = PASS;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= PASS;
            ones_cnt  <= 3'd0;
            pend_last <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            state     <= state_nxt;
            ones_cnt  <= cnt_nxt;
            pend_last <= pend_nxt;
            out_valid <= beat_nxt.valid;
            out_last  <= beat_nxt.last;
        end
    end

`ifdef USB_BIT_STUFF_NRZI_EN
    logic level;

    nrzi_encoder u_nrzi (
        .clock   (clock),
        .reset_n (reset_n),
        .valid   (beat_nxt.valid),
        .last    (beat_nxt.last),
        .raw_bit (beat_nxt.data),
        .level   (level)
    );

    assign out_bit = level;
`else
    logic raw_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) raw_q <= 1'b1;
        else          raw_q <= beat_nxt.data;
    end

    assign out_bit = raw_q;
`endif

endmodule

// File: tb/tb_usb_bit_stuffer.sv
// Directed bench for usb_bit_stuffer; expected out_bit follows NRZI when USB_BIT_STUFF_NRZI_EN is set.
module tb_usb_bit_stuffer;

    logic clock, reset_n;
    logic in_valid, in_bit, in_last;
    logic in_ready, out_valid, out_bit, out_last;

    int vectors     = 0;
    int miscompares = 0;

    // NRZI reference: line level and whether the previous beat closed a packet.
    logic m_lvl  = 1'b1;
    logic m_last = 1'b0;

    usb_bit_stuffer dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_bit   (out_bit),
        .out_last  (out_last)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input logic got, input logic exp, input string tag);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    // Offer one upstream beat across one clock edge, then check the registered result.
    task automatic beat(input logic v, b, l, input logic rdy, ov, ob, ol, input string tag);
        logic base;
        in_valid = v; in_bit = b; in_last = l;
        #1;
        chk(in_ready, rdy, {tag, ".in_ready"});
        @(posedge clock);
        #1;
        chk(out_valid, ov, {tag, ".out_valid"});
        chk(out_last, ol, {tag, ".out_last"});
`ifdef USB_BIT_STUFF_NRZI_EN
        base   = m_last ? 1'b1 : m_lvl;
        m_lvl  = (ov && !ob) ? ~base : base;
        m_last = ov && ol;
        chk(out_bit, m_lvl, {tag, ".out_level"});
`else
        if (ov) chk(out_bit, ob, {tag, ".out_bit"});
`endif
    endtask

    task automatic chk_reset_vals(input string tag);
        chk(out_valid, 1'b0, {tag, ".out_valid"});
        chk(out_bit, 1'b1, {tag, ".out_bit"});
        chk(out_last, 1'b0, {tag, ".out_last"});
        chk(in_ready, 1'b1, {tag, ".in_ready"});
    endtask

    initial begin
        logic [15:0] tok;
        reset_n = 1'b0; in_valid = 1'b0; in_bit = 1'b0; in_last = 1'b0;
        #12;
        chk_reset_vals("rst");
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock); #1;

        // 0x7F LSB-first: six 1s, stuffed 0, seventh 1, trailing 0 with last
        for (int i = 0; i < 6; i++) beat(1, 1, 0, 1, 1, 1, 0, "x7f.one");
        beat(1, 1, 0, 0, 1, 0, 0, "x7f.stuff");
        beat(1, 1, 0, 1, 1, 1, 0, "x7f.b6");
        beat(1, 0, 1, 1, 1, 0, 1, "x7f.b7");
        beat(0, 0, 0, 1, 0, 1, 0, "x7f.idle");

        // Token + CRC5: never six 1s, output mirrors input one cycle late
        tok = 16'b11101_01000000101;
        for (int i = 0; i < 16; i++)
            beat(1, tok[i], i == 15, 1, 1, tok[i], i == 15, "tok");
        beat(0, 0, 0, 1, 0, 1, 0, "tok.idle");

        // Run of six split by a two-cycle gap
        for (int i = 0; i < 3; i++) beat(1, 1, 0, 1, 1, 1, 0, "gap.a");
        beat(0, 0, 0, 1, 0, 1, 0, "gap.hole0");
        beat(0, 0, 0, 1, 0, 1, 0, "gap.hole1");
        for (int i = 0; i < 3; i++) beat(1, 1, 0, 1, 1, 1, 0, "gap.b");
        beat(0, 0, 0, 0, 1, 0, 0, "gap.stuff");
        beat(0, 0, 0, 1, 0, 1, 0, "gap.idle");

        // Packet ends on the sixth 1: last moves to the stuffed 0
        for (int i = 0; i < 5; i++) beat(1, 1, 0, 1, 1, 1, 0, "term.one");
        beat(1, 1, 1, 1, 1, 1, 0, "term.six");
        beat(1, 1, 0, 0, 1, 0, 1, "term.stuff");
        beat(1, 1, 0, 1, 1, 1, 0, "next.b0");
        beat(1, 0, 1, 1, 1, 0, 1, "next.b1");
        beat(0, 0, 0, 1, 0, 1, 0, "next.idle");

        // Reset after five 1s discards the run
        for (int i = 0; i < 5; i++) beat(1, 1, 0, 1, 1, 1, 0, "mid.one");
        reset_n = 1'b0; in_valid = 1'b0;
        #1;
        chk_reset_vals("mid.rst_async");
        @(posedge clock); #1;
        chk_reset_vals("mid.rst_held");
        reset_n = 1'b1;
        m_lvl = 1'b1; m_last = 1'b0;
        beat(1, 1, 1, 1, 1, 1, 1, "mid.one_after");
        beat(0, 0, 0, 1, 0, 1, 0, "mid.no_stuff");

        // 0,0,1,1 -> NRZI levels 0,1,1,1 then back to idle 1
        beat(1, 0, 0, 1, 1, 0, 0, "nrzi.b0");
        beat(1, 0, 0, 1, 1, 0, 0, "nrzi.b1");
        beat(1, 1, 0, 1, 1, 1, 0, "nrzi.b2");
        beat(1, 1, 1, 1, 1, 1, 1, "nrzi.b3");
        beat(0, 0, 0, 1, 0, 1, 0, "nrzi.idle");
`ifdef USB_BIT_STUFF_NRZI_EN
        chk(out_bit, 1'b1, "nrzi.idle_level");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
